// File: rtl/fp16_pkg.sv
// fp16 field layout, constants and dot-product sequencer state type.
// Imported by the fp16 arithmetic, the sequencer FSM and fp16_dot_seq.
package fp16_pkg;

  localparam int FP16_W   = 16;
  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int MAN_MSB  = 9;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dot_state_t;

endpackage

// File: rtl/fp16_arith.sv
// Combinational fp16 multiply and add, truncating.
// Ports: a, b operands in; y result out. No zero/NaN/Inf/denormal handling.
module fp16_mul
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic [FP16_W-1:0] y
);

  logic [21:0] p;

  always_comb begin
    p = {11'b0, 1'b1, a[MAN_MSB:0]} * {11'b0, 1'b1, b[MAN_MSB:0]};
    y[SIGN_BIT] = a[SIGN_BIT] ^ b[SIGN_BIT];
    // Exponent wraps freely; overflow is not handled.
    y[EXP_MSB:EXP_LSB] = 5'({2'b0, a[EXP_MSB:EXP_LSB]}
                          + {2'b0, b[EXP_MSB:EXP_LSB]}
                          - 7'd15 + {6'b0, p[21]});
    y[MAN_MSB:0] = 10'(p[21] ? (p >> 11) : (p >> 10));
  end

endmodule

module fp16_add
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic [FP16_W-1:0] y
);

  logic [FP16_W-1:0] x, s;
  logic [4:0]        d, e;
  logic [13:0]       mx, my, norm;
  logic [14:0]       sum;
  logic [3:0]        n;
  logic              found;

  always_comb begin
    // x is the larger magnitude so the result takes its sign.
    if (a[EXP_MSB:0] < b[EXP_MSB:0]) begin
      x = b;
      s = a;
    end else begin
      x = a;
      s = b;
    end
    d  = x[EXP_MSB:EXP_LSB] - s[EXP_MSB:EXP_LSB];
    mx = {1'b1, x[MAN_MSB:0], 3'b000};
    my = {1'b1, s[MAN_MSB:0], 3'b000} >> d;
    if (x[SIGN_BIT] == s[SIGN_BIT]) sum = {1'b0, mx} + {1'b0, my};
    else                            sum = {1'b0, mx} - {1'b0, my};
    n     = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && sum[i]) begin
        n     = 4'(13 - i);
        found = 1'b1;
      end
    end
    if (sum[14]) begin
      norm = sum[14:1];
      e    = x[EXP_MSB:EXP_LSB] + 5'd1;
    end else begin
      norm = sum[13:0] << n;
      e    = x[EXP_MSB:EXP_LSB] - {1'b0, n};
    end
    if (sum == '0) y = FP16_ZERO;
    else           y = {x[SIGN_BIT], e, 10'(norm >> 3)};
  end

endmodule

// File: rtl/fp16_dot_seq_fsm.sv
// Dot-product sequencer control: state, element count, first flag, handshakes.
// Ports: start/len, in_valid/in_ready, res_valid/res_ready, busy, acc_we/acc_first/acc_clr. Macro FP16_DOT_PIPE_EN.
module fp16_dot_fsm
  import fp16_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             acc_we,
  output logic             acc_first,
  output logic             acc_clr
);

  dot_state_t       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
`ifdef FP16_DOT_PIPE_EN
  logic             pend_q, pend_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
`ifdef FP16_DOT_PIPE_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
`ifdef FP16_DOT_PIPE_EN
      pend_q  <= pend_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
`ifdef FP16_DOT_PIPE_EN
    pend_d    = pend_q;
`endif
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = (state_q != IDLE);
    acc_we    = 1'b0;
    acc_first = first_q;
    acc_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = RUN;
            cnt_d   = len;
            first_d = 1'b1;
          end else begin
            state_d = DONE;
            acc_clr = 1'b1;
          end
        end
      end
      RUN: begin
`ifdef FP16_DOT_PIPE_EN
        // pend marks the add cycle of a registered product.
        in_ready = !pend_q;
        if (pend_q) begin
          acc_we  = 1'b1;
          first_d = 1'b0;
          pend_d  = 1'b0;
          if (cnt_q == '0) state_d = DONE;
        end else if (in_valid) begin
          pend_d = 1'b1;
          cnt_d  = cnt_q - LEN_W'(1);
        end
`else
        in_ready = 1'b1;
        if (in_valid) begin
          acc_we  = 1'b1;
          first_d = 1'b0;
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DONE;
        end
`endif
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/fp16_dot_seq.sv
// fp16 dot product over a run-time length through one shared mul/add.
// Ports: clk, rst, start, len, a_data, b_data, in_valid/in_ready, res_data/res_valid/res_ready, busy. Macro FP16_DOT_PIPE_EN.
module fp16_dot_seq
  import fp16_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [FP16_W-1:0] a_data,
  input  logic [FP16_W-1:0] b_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FP16_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  logic [FP16_W-1:0] prod, addend, sum, acc_q;
  logic              acc_we, acc_first, acc_clr;

  fp16_dot_fsm #(.LEN_W(LEN_W)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .acc_we    (acc_we),
    .acc_first (acc_first),
    .acc_clr   (acc_clr)
  );

  fp16_mul u_mul (.a(a_data), .b(b_data), .y(prod));

`ifdef FP16_DOT_PIPE_EN
  logic [FP16_W-1:0] prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        prod_q <= FP16_ZERO;
    else if (in_valid && in_ready)  prod_q <= prod;
  end

  assign addend = prod_q;
`else
  assign addend = prod;
`endif

  fp16_add u_add (.a(acc_q), .b(addend), .y(sum));

  // First product loads directly: there is no zero to add against.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          acc_q <= FP16_ZERO;
    else if (acc_clr) acc_q <= FP16_ZERO;
    else if (acc_we)  acc_q <= acc_first ? addend : sum;
  end

  assign res_data = acc_q;

endmodule
